// File: rtl/signed_addsub_acc.sv
// Registered signed add/sub/accumulate unit with overflow detection, optional
// saturation, and a single-stage valid/ready output register.
module signed_addsub_acc #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SATURATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             ovf_sticky,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_t;

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  op_t              op_e;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH:0]   ext_a, ext_b, ext_acc;
  logic [WIDTH:0]   full;
  logic             full_ovf;
  logic [WIDTH-1:0] result;

  assign op_e      = op_t'(op);
  assign out_valid = (state_q == ST_HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign ext_a   = {a[WIDTH-1], a};
  assign ext_b   = {b[WIDTH-1], b};
  assign ext_acc = {acc_q[WIDTH-1], acc_q};

  // One extra bit of headroom makes overflow (including 0 - MIN) a simple
  // disagreement between the top two bits.
  always_comb begin
    full = '0;
    unique case (op_e)
      OP_ADD: full = ext_a + ext_b;
      OP_SUB: full = ext_a - ext_b;
      OP_ACC: full = ext_acc + ext_a;
      OP_CLR: full = '0;
      default: full = '0;
    endcase
  end

  assign full_ovf = full[WIDTH] ^ full[WIDTH-1];

  always_comb begin
    result = full[WIDTH-1:0];
    if (full_ovf && (SATURATE != 0)) begin
      result = full[WIDTH] ? MIN_VAL : MAX_VAL;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_fire) state_d = ST_HOLD;
      ST_HOLD: if (out_fire && !in_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    acc_d    = acc_q;
    if (in_fire) begin
      sum_d = result;
      ovf_d = full_ovf;
      if (op_e == OP_CLR) begin
        acc_d    = '0;
        sticky_d = 1'b0;
      end else begin
        if (op_e == OP_ACC) acc_d = result;
        if (full_ovf) sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      acc_q    <= acc_d;
    end
  end

  assign sum        = sum_q;
  assign overflow   = ovf_q;
  assign ovf_sticky = sticky_q;
  assign acc        = acc_q;

endmodule

// File: tb/tb_signed_addsub_acc.sv
// Scoreboard bench: two instances (saturating and wrapping) share stimulus;
// expected beats come from an integer-arithmetic reference model.
module tb_signed_addsub_acc;

  localparam int W    = 4;
  localparam int MAXV = 7;
  localparam int MINV = -8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_ready = 1'b0;

  logic         in_ready0, out_valid0, overflow0, sticky0;
  logic [W-1:0] sum0, acc0;
  logic         in_ready1, out_valid1, overflow1, sticky1;
  logic [W-1:0] sum1, acc1;

  int ntests = 0;
  int nfail  = 0;

  exp_t         q0[$];
  exp_t         q1[$];
  logic [W-1:0] m_acc [2];
  logic         m_stk [2];
  logic [W-1:0] m_lsum[2];
  logic         m_lovf[2];

  always #5 clk = ~clk;

  signed_addsub_acc #(.WIDTH(W), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .op(op), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .sum(sum0), .overflow(overflow0), .ovf_sticky(sticky0), .acc(acc0)
  );

  signed_addsub_acc #(.WIDTH(W), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .overflow(overflow1), .ovf_sticky(sticky1), .acc(acc1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, then range test and clamp/wrap.
  task automatic issue(input int k, input bit sat, input logic [1:0] o,
                       input logic [W-1:0] aa, input logic [W-1:0] bb);
    logic signed [W-1:0] sa, sb, sacc;
    int   full, r;
    bit   ov;
    exp_t e;
    sa = aa; sb = bb; sacc = m_acc[k];
    case (o)
      2'b00:   full = int'(sa) + int'(sb);
      2'b01:   full = int'(sa) - int'(sb);
      2'b10:   full = int'(sacc) + int'(sa);
      default: full = 0;
    endcase
    ov = (full > MAXV) || (full < MINV);
    if (!ov)      r = full;
    else if (sat) r = (full > MAXV) ? MAXV : MINV;
    else          r = (full > MAXV) ? full - 16 : full + 16;
    e.sum = W'(r);
    e.ovf = ov;
    if (o == 2'b11) begin
      m_acc[k] = '0;
      m_stk[k] = 1'b0;
    end else begin
      if (o == 2'b10) m_acc[k] = e.sum;
      if (ov) m_stk[k] = 1'b1;
    end
    m_lsum[k] = e.sum;
    m_lovf[k] = e.ovf;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic mon(input int k, input logic ov, input logic [W-1:0] s, input logic of,
                     input logic [W-1:0] ac, input logic st, input logic ir);
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : q1.size();
    check($sformatf("out_valid%0d", k), {31'b0, ov}, {31'b0, (sz > 0)});
    check($sformatf("in_ready%0d", k), {31'b0, ir}, {31'b0, (!ov || out_ready)});
    check($sformatf("acc%0d", k), {28'b0, ac}, {28'b0, m_acc[k]});
    check($sformatf("sticky%0d", k), {31'b0, st}, {31'b0, m_stk[k]});
    if (ov && sz > 0) begin
      e = (k == 0) ? q0[0] : q1[0];
      check($sformatf("sum%0d", k), {28'b0, s}, {28'b0, e.sum});
      check($sformatf("overflow%0d", k), {31'b0, of}, {31'b0, e.ovf});
      if (out_ready) begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end else begin
      check($sformatf("sum_hold%0d", k), {28'b0, s}, {28'b0, m_lsum[k]});
      check($sformatf("ovf_hold%0d", k), {31'b0, of}, {31'b0, m_lovf[k]});
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, out_valid0, sum0, overflow0, acc0, sticky0, in_ready0);
      mon(1, out_valid1, sum1, overflow1, acc1, sticky1, in_ready1);
    end
  end

  // Drives one cycle starting just after a rising edge; returns just after the next.
  task automatic cyc(input logic v, input logic [1:0] o, input logic [W-1:0] aa,
                     input logic [W-1:0] bb, input logic ordy);
    in_valid = v; op = o; a = aa; b = bb; out_ready = ordy;
    @(negedge clk); #1;
    if (v && in_ready0) begin
      issue(0, 1'b1, o, aa, bb);
      issue(1, 1'b0, o, aa, bb);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = '0; m_stk[k] = 1'b0; m_lsum[k] = '0; m_lovf[k] = 1'b0;
    end
    check("rst_out_valid", {31'b0, out_valid0}, 32'd0);
    check("rst_sum", {28'b0, sum0}, 32'd0);
    check("rst_overflow", {31'b0, overflow1}, 32'd0);
    check("rst_sticky", {31'b0, sticky0}, 32'd0);
    check("rst_acc", {28'b0, acc0}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready0}, 32'd1);
  endtask

  task automatic expect_now(input string name, input logic [W-1:0] s0, input logic [W-1:0] s1,
                            input logic ov);
    check({name, "_sat"}, {28'b0, sum0}, {28'b0, s0});
    check({name, "_wrap"}, {28'b0, sum1}, {28'b0, s1});
    check({name, "_ovf"}, {30'b0, overflow0, overflow1}, {30'b0, ov, ov});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    cyc(1, 2'b00, 4'd3, 4'd2, 1);
    expect_now("add_3_2", 4'd5, 4'd5, 1'b0);
    cyc(0, 2'b00, 4'd0, 4'd0, 1);
    check("idle_after_add", {31'b0, out_valid0}, 32'd0);

    cyc(1, 2'b00, 4'd7, 4'd1, 1);
    expect_now("add_7_1", 4'h7, 4'h8, 1'b1);
    check("sticky_7_1", {30'b0, sticky0, sticky1}, 32'd3);
    cyc(1, 2'b01, 4'h8, 4'd1, 1);
    expect_now("sub_m8_1", 4'h8, 4'h7, 1'b1);
    cyc(1, 2'b01, 4'd0, 4'h8, 1);
    expect_now("sub_0_m8", 4'h7, 4'h8, 1'b1);

    cyc(1, 2'b11, 4'd0, 4'd0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 2'b10, 4'd3, 4'd0, 1);
    check("acc_sat_final", {28'b0, acc0}, 32'd7);
    cyc(1, 2'b11, 4'd5, 4'd5, 1);
    check("clr_acc", {28'b0, acc0}, 32'd0);
    check("clr_sticky", {31'b0, sticky0}, 32'd0);

    cyc(1, 2'b00, 4'd1, 4'd1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'b00, 4'd2, 4'd2, 0);
      check("stall_sum", {28'b0, sum0}, 32'd2);
    end
    check("stall_in_ready", {31'b0, in_ready0}, 32'd0);
    cyc(1, 2'b00, 4'd2, 4'd2, 1);
    check("unstall_sum", {28'b0, sum0}, 32'd4);

    for (int i = 0; i <= 6; i++) begin
      logic [W-1:0] ai, bi;
      ai = W'(i); bi = W'(2 * i);
      cyc(1, 2'b00, ai, bi, 1);
    end

    cyc(1, 2'b11, 4'd0, 4'd0, 1);
    cyc(1, 2'b10, 4'd5, 4'd0, 1);
    cyc(0, 2'b00, 4'd0, 4'd0, 0);
    check("pre_rst_acc", {28'b0, acc0}, 32'd5);
    check("pre_rst_valid", {31'b0, out_valid0}, 32'd1);
    do_reset();

    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(3) != 0), 2'($urandom_range(3)), W'($urandom),
          W'($urandom), ($urandom_range(9) < 7));
    end

    begin
      int budget = 20;
      while ((q0.size() != 0 || q1.size() != 0) && budget > 0) begin
        cyc(0, 2'b00, 4'd0, 4'd0, 1);
        budget--;
      end
      check("drain_q0", q0.size(), 32'd0);
      check("drain_q1", q1.size(), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/signed_addsub_acc.md
Name: signed_addsub_acc

Overview:
Parametrised, registered signed arithmetic unit that replaces the flat 4-bit combinational signed adder. It supports add, subtract, accumulate and accumulator-clear operations. Overflow is detected, and the result either saturates or wraps, selected by a parameter. A valid/ready handshake on both sides lets it sit between streaming stages in the datapath.

Parameters:
WIDTH, 4, operand/result width in bits, two's complement, min 2
SATURATE, 1, 1 = clamp on overflow; 0 = wrap (drop carry)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
op  input  2  00 ADD (a+b), 01 SUB (a-b), 10 ACC (acc+a), 11 CLR (acc=0)
a  input  WIDTH  signed operand A
b  input  WIDTH  signed operand B (ignored for ACC/CLR)
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  signed result
overflow  output  1  overflow occurred on this result beat
ovf_sticky  output  1  OR of all overflow since last reset/CLR
acc  output  WIDTH  current accumulator value

Behaviour:
- Reset: on a clk edge with reset=1, the following are forced to 0: out_valid, sum, overflow, ovf_sticky, acc. The next cycle has in_ready=1. Reset wins over any in-flight or simultaneous transfer. Reset mid-stall discards the held result.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single output stage, no skid buffer).
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Latency: 1 cycle. The result is registered on the edge where the input transfers. out_valid goes high the next cycle.
- Back-to-back: with out_ready held high, one result per cycle.
- Stall: with out_valid=1 and out_ready=0, sum and overflow are held stable, in_ready=0, acc is unchanged, and inputs are ignored.
- Simultaneous output and input transfer in one cycle: the new result replaces the old one, and out_valid stays 1.
- When out_valid drops (output transfer, no input transfer), sum and overflow keep their last values.
- Arithmetic:
  - Compute in WIDTH+1 bits: full = sext(a) + sext(b), or sext(a) - sext(b), or sext(acc) + sext(a).
  - overflow = full[WIDTH] XOR full[WIDTH-1].
  - No overflow: result = full[WIDTH-1:0].
  - Overflow with SATURATE=1: result = MAX (0111..1) if full[WIDTH]=0, else MIN (1000..0).
  - Overflow with SATURATE=0: result = full[WIDTH-1:0] (wrap).
  - SUB with b = MIN is handled correctly by the WIDTH+1 computation. For example, 0 - (-8) at WIDTH=4 overflows.
- Accumulator:
  - ACC: acc <= result, and sum = the same result.
  - CLR: acc <= 0, sum = 0, overflow = 0, ovf_sticky <= 0. out_valid is still produced for CLR.
  - ADD/SUB do not modify acc.
  - acc changes only on an input transfer.
- ovf_sticky: set on any transferred beat whose overflow=1. It is cleared only by reset or CLR. If CLR and an overflow would coincide, CLR wins (CLR itself never overflows).
- No internal FSM beyond the state above: IDLE (out_valid=0) and HOLD (out_valid=1).
  - IDLE -> HOLD on input transfer.
  - HOLD -> IDLE on output transfer without input transfer.
  - HOLD -> HOLD otherwise.

Test Plan:
- Reset then ADD a=3, b=2 (WIDTH=4, SATURATE=1), out_ready=1 -> next cycle out_valid=1, sum=5, overflow=0; the cycle after, out_valid=0.
- Saturation, SATURATE=1:
  - ADD 7+1 -> sum=7, overflow=1, ovf_sticky=1.
  - SUB -8-1 -> sum=-8 (4'h8), overflow=1.
  - SUB 0-(-8) -> sum=7, overflow=1.
  - Repeat all three with SATURATE=0 -> sums 4'h8, 4'h7, 4'h8 respectively, overflow=1.
- Accumulate: CLR, then ACC a=3 four times -> sums 3, 6, 7 (sat, overflow=1), 7 (overflow=1); acc=7, ovf_sticky=1. Then CLR -> sum=0, acc=0, ovf_sticky=0.
- Back-pressure:
  - ADD 1+1 accepted, out_ready=0 for 3 cycles while in_valid=1 with ADD 2+2 -> in_ready=0, sum held at 2 for all 3 cycles.
  - Raise out_ready -> 2+2 is accepted in that cycle, and sum=4 on the next.
- Streaming: a=i, b=2i for i=0..6 (the original 4-bit sweep pattern), in_valid and out_ready held high -> one result per cycle, sums 0, 3, 6, 7 (sat), 7, 7, 7, with overflow set from i=3 on (i=3: 3+6 overflows).
- Reset mid-operation: assert reset while out_valid=1, out_ready=0 and acc=5 -> next cycle out_valid=0, sum=0, acc=0, ovf_sticky=0, in_ready=1.
